// File: rtl/gpio_regfile_irq.sv
// GPIO register file: byte-lane writable config registers, pin synchroniser,
// sticky per-pin level/edge interrupt status and a registered interrupt request.
module gpio_regfile_irq #(
  parameter int unsigned GPIO_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:2]            addr,
  input  logic [3:0]            wben,
  input  logic                  r_wn,
  input  logic [31:0]           wdata,
  input  logic [GPIO_WIDTH-1:0] ro_gpio_pinstate,
  output logic [31:0]           rdata,
  output logic [GPIO_WIDTH-1:0] rf_gpio_datareg,
  output logic [GPIO_WIDTH-1:0] rf_gpio_tristate,
  output logic [GPIO_WIDTH-1:0] rf_gpio_interrupt_mask,
  output logic                  gpio_irq
);

  localparam int unsigned W           = GPIO_WIDTH;
  localparam logic [2:0]  WARM_CYCLES = 3'(SYNC_STAGES + 1);

  typedef enum logic [2:0] {
    A_DATA     = 3'd0,
    A_TRISTATE = 3'd1,
    A_PINSTATE = 3'd2,
    A_IRQ_MASK = 3'd3,
    A_IRQ_TYPE = 3'd4,
    A_IRQ_POL  = 3'd5,
    A_IRQ_STAT = 3'd6,
    A_TOGGLE   = 3'd7
  } reg_addr_e;

  reg_addr_e reg_sel;
  assign reg_sel = reg_addr_e'(addr);

  logic [W-1:0] data_q, tri_q, mask_q, type_q, pol_q, status_q;
  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] prev_q;
  logic [2:0]   warm_q;

  logic [31:0] lane_mask, wr_bits;
  logic [W-1:0] wmask_w, wbits_w;
  logic        wr_en;
  logic        unused_hi;

  always_comb begin
    lane_mask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      lane_mask[8*i +: 8] = {8{wben[i]}};
    end
  end

  assign wr_bits   = wdata & lane_mask;
  assign wmask_w   = lane_mask[W-1:0];
  assign wbits_w   = wr_bits[W-1:0];
  assign wr_en     = !r_wn && (wben != 4'b0000);
  // Bits above GPIO_WIDTH have no storage behind them.
  assign unused_hi = ^wr_bits;

  function automatic logic [W-1:0] merge(input logic [W-1:0] old,
                                         input logic [W-1:0] msk,
                                         input logic [W-1:0] bits);
    return (old & ~msk) | bits;
  endfunction

  function automatic logic [31:0] zext(input logic [W-1:0] v);
    logic [31:0] r;
    r        = '0;
    r[W-1:0] = v;
    return r;
  endfunction

  // Pin synchroniser and one-cycle-delayed copy for edge detection.
  logic [W-1:0] pin_sync;
  assign pin_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= ro_gpio_pinstate;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= pin_sync;
    end
  end

  // Edge events stay blocked until the synchroniser and prev[] hold real pin data.
  logic warm_done;
  assign warm_done = (warm_q == WARM_CYCLES);

  always_ff @(posedge clk) begin
    if (reset)           warm_q <= '0;
    else if (!warm_done) warm_q <= warm_q + 3'd1;
  end

  logic [W-1:0] rise, fall, edge_evt, level_evt, evt, clr, status_nxt;

  always_comb begin
    rise       = pin_sync & ~prev_q;
    fall       = ~pin_sync & prev_q;
    edge_evt   = (pol_q & rise) | (~pol_q & fall);
    level_evt  = ~(pin_sync ^ pol_q);
    evt        = (type_q & edge_evt & {W{warm_done}}) | (~type_q & level_evt);
    clr        = (wr_en && reg_sel == A_IRQ_STAT) ? wbits_w : '0;
    // Clear first, then OR in events so a same-edge event wins.
    status_nxt = (status_q & ~clr) | evt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      tri_q    <= '1;
      mask_q   <= '0;
      type_q   <= '0;
      pol_q    <= '0;
      status_q <= '0;
    end else begin
      status_q <= status_nxt;
      if (wr_en) begin
        case (reg_sel)
          A_DATA:     data_q <= merge(data_q, wmask_w, wbits_w);
          A_TRISTATE: tri_q  <= merge(tri_q,  wmask_w, wbits_w);
          A_IRQ_MASK: mask_q <= merge(mask_q, wmask_w, wbits_w);
          A_IRQ_TYPE: type_q <= merge(type_q, wmask_w, wbits_w);
          A_IRQ_POL:  pol_q  <= merge(pol_q,  wmask_w, wbits_w);
          A_TOGGLE:   data_q <= data_q ^ wbits_w;
          default:    ;
        endcase
      end
    end
  end

  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      A_DATA:     rd_word = zext(data_q);
      A_TRISTATE: rd_word = zext(tri_q);
      A_PINSTATE: rd_word = zext(pin_sync);
      A_IRQ_MASK: rd_word = zext(mask_q);
      A_IRQ_TYPE: rd_word = zext(type_q);
      A_IRQ_POL:  rd_word = zext(pol_q);
      A_IRQ_STAT: rd_word = zext(status_q);
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= '0;
      gpio_irq <= 1'b0;
    end else begin
      if (r_wn) rdata <= rd_word;
      gpio_irq <= |(status_q & mask_q);
    end
  end

  assign rf_gpio_datareg        = data_q;
  assign rf_gpio_tristate       = tri_q;
  assign rf_gpio_interrupt_mask = mask_q;

endmodule

// File: tb/tb_gpio_regfile_irq.sv
// Self-checking bench for gpio_regfile_irq: register access, pin-to-interrupt
// timing, W1C behaviour, edge warm-up, plus an 8-bit-wide instance.
module tb_gpio_regfile_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:2]  addr;
  logic [3:0]  wben;
  logic        r_wn;
  logic [31:0] wdata;
  logic [15:0] pins;

  logic [31:0] rdata;
  logic [15:0] datareg, tristate, irq_mask;
  logic        gpio_irq;

  logic [31:0] rdata8;
  logic [7:0]  datareg8, tristate8, irq_mask8;
  logic        gpio_irq8;

  always #5 clk = ~clk;

  gpio_regfile_irq #(.GPIO_WIDTH(16), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .addr(addr), .wben(wben), .r_wn(r_wn),
    .wdata(wdata), .ro_gpio_pinstate(pins), .rdata(rdata),
    .rf_gpio_datareg(datareg), .rf_gpio_tristate(tristate),
    .rf_gpio_interrupt_mask(irq_mask), .gpio_irq(gpio_irq)
  );

  gpio_regfile_irq #(.GPIO_WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .reset(reset), .addr(addr), .wben(wben), .r_wn(r_wn),
    .wdata(wdata), .ro_gpio_pinstate(pins[7:0]), .rdata(rdata8),
    .rf_gpio_datareg(datareg8), .rf_gpio_tristate(tristate8),
    .rf_gpio_interrupt_mask(irq_mask8), .gpio_irq(gpio_irq8)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
    addr  = a;
    wben  = be;
    wdata = d;
    r_wn  = 1'b0;
    tick();
    wben  = 4'b0000;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
    addr = a;
    r_wn = 1'b1;
    tick();
    r_wn = 1'b0;
    it = sb.pop_front();
    check(it.tag, rdata, it.exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; addr = '0; wben = '0; r_wn = 1'b0; wdata = '0; pins = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_datareg",  32'(datareg),  32'h0000);
    check("rst_tristate", 32'(tristate), 32'hFFFF);
    check("rst_mask",     32'(irq_mask), 32'h0000);
    check("rst_irq",      32'(gpio_irq), 32'h0);
    check("rst_rdata",    rdata,         32'h0);
    reset = 1'b0;

    // Status is still clear on the first edge; pins low then raise level-low events.
    rd(3'd6, 32'h0000, "status_first");
    check("irq_after_rst", 32'(gpio_irq), 32'h0);
    rd(3'd0, 32'h0000, "rd_data");
    rd(3'd1, 32'hFFFF, "rd_tristate");
    rd(3'd2, 32'h0000, "rd_pinstate");
    rd(3'd3, 32'h0000, "rd_mask");
    rd(3'd4, 32'h0000, "rd_type");
    rd(3'd5, 32'h0000, "rd_pol");
    rd(3'd7, 32'h0000, "rd_toggle");
    rd(3'd6, 32'hFFFF, "status_level_low");
    check("irq_unmasked", 32'(gpio_irq), 32'h0);

    wr(3'd4, 4'hF, 32'h0000FFFF);
    wr(3'd6, 4'hF, 32'h0000FFFF);
    rd(3'd6, 32'h0000, "status_cleared");

    wr(3'd0, 4'b0101, 32'h12345678);
    check("data_bytelane", 32'(datareg), 32'h0078);
    wr(3'd7, 4'hF, 32'h000000FF);
    check("data_toggle", 32'(datareg), 32'h0087);
    rd(3'd0, 32'h0087, "rd_data_toggled");
    rd(3'd7, 32'h0000, "rd_toggle_zero");

    wr(3'd1, 4'b0001, 32'h0000A5A5);
    check("tri_lane0", 32'(tristate), 32'hFFA5);
    wr(3'd1, 4'b0010, 32'h00003C00);
    rd(3'd1, 32'h3CA5, "rd_tri_lane1");
    wr(3'd2, 4'hF, 32'h0000FFFF);
    rd(3'd2, 32'h0000, "pinstate_ro");

    // Rising edge on pin0: status at k+2, gpio_irq at k+3.
    wr(3'd5, 4'hF, 32'h1);
    wr(3'd3, 4'hF, 32'h1);
    check("mask_out", 32'(irq_mask), 32'h0001);
    pins[0] = 1'b1;
    tick();
    tick();
    rd(3'd6, 32'h0000, "edge_k2_pre");
    check("irq_k2", 32'(gpio_irq), 32'h0);
    rd(3'd6, 32'h0001, "edge_k3_status");
    check("irq_k3", 32'(gpio_irq), 32'h1);
    rd(3'd2, 32'h0001, "pinstate_pin0");
    wr(3'd6, 4'hF, 32'h1);
    check("irq_w1c_same", 32'(gpio_irq), 32'h1);
    tick();
    check("irq_w1c_next", 32'(gpio_irq), 32'h0);

    // Level-high on pin3 cannot be cleared while active.
    wr(3'd5, 4'hF, 32'h9);
    wr(3'd4, 4'hF, 32'hFFF7);
    pins[3] = 1'b1;
    repeat (4) tick();
    rd(3'd6, 32'h0008, "level_set");
    wr(3'd6, 4'hF, 32'h8);
    rd(3'd6, 32'h0008, "level_resets");
    pins[3] = 1'b0;
    repeat (4) tick();
    wr(3'd6, 4'hF, 32'h8);
    rd(3'd6, 32'h0000, "level_released");
    check("irq_level_masked", 32'(gpio_irq), 32'h0);

    // Edge event and W1C on the same edge: set wins.
    wr(3'd5, 4'hF, 32'hB);
    pins[1] = 1'b1;
    tick();
    tick();
    wr(3'd6, 4'hF, 32'h2);
    rd(3'd6, 32'h0002, "set_wins");
    wr(3'd6, 4'hF, 32'h2);
    rd(3'd6, 32'h0000, "set_wins_clear");

    // Reset mid-operation with a write in flight; pin0 high through reset.
    pins  = 16'h0001;
    reset = 1'b1;
    wr(3'd0, 4'hF, 32'h0000AAAA);
    tick();
    reset = 1'b0;
    check("rst_discard_wr", 32'(datareg), 32'h0000);
    wr(3'd4, 4'hF, 32'h0000FFFF);
    wr(3'd5, 4'hF, 32'h1);
    wr(3'd6, 4'hF, 32'h0000FFFF);
    rd(3'd6, 32'h0000, "warmup_blocked");
    wr(3'd5, 4'hF, 32'h0);
    pins[0] = 1'b0;
    repeat (3) tick();
    rd(3'd6, 32'h0001, "falling_after_warm");

    // Narrow instance ignores bits above its width.
    wr(3'd1, 4'hF, 32'hFFFFFFFF);
    rd(3'd1, 32'h0000FFFF, "tri16_all");
    check("tri8_rdata", rdata8, 32'h000000FF);
    check("tri8_out", 32'(tristate8), 32'h000000FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
